// File: rtl/mult_iter_pkg.sv
// mult_iter_pkg: shared state encoding and operand helpers for the iterative multiplier
package mult_iter_pkg;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

    // v is sign- or zero-extended to MAX_W by the caller
    function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] v, input logic sgn);
        return (sgn && v[MAX_W-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/mult_iter_step.sv
// mult_iter_step: one iteration of shift-add, retiring STEP multiplier bits
module mult_iter_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
)(
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mc,
    input  logic [STEP-1:0]    mp_lo,
    output logic [2*WIDTH-1:0] acc_next
);
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < STEP; i++)
            acc_next = acc_next + (mp_lo[i] ? (mc << i) : '0);
    end
endmodule

// File: rtl/multiplier_iterative_param.sv
// multiplier_iterative_param: valid/ready iterative shift-add multiplier with early exit
module multiplier_iterative_param
    import mult_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_in,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [2*WIDTH-1:0] r
);
    localparam int PW    = 2 * WIDTH;
    localparam int ITERS = WIDTH / STEP;
    localparam int CW    = $clog2(ITERS + 1);

    if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP != 0) || WIDTH < 4 || WIDTH > MAX_W
        || (WIDTH % 2 != 0)) begin : g_bad_params
        $error("multiplier_iterative_param: illegal WIDTH/STEP");
    end

    mult_state_t      state;
    logic [PW-1:0]    acc, mc, acc_next;
    logic [WIDTH-1:0] mp, mp_next, a_mag, b_mag;
    logic [CW-1:0]    cnt, cnt_next;
    logic             neg, finish;
    logic [MAX_W-1:0] a_ext, b_ext;

    assign a_ext     = signed_in ? MAX_W'($signed(a)) : MAX_W'(a);
    assign b_ext     = signed_in ? MAX_W'($signed(b)) : MAX_W'(b);
    assign a_mag     = WIDTH'(mag(a_ext, signed_in));
    assign b_mag     = WIDTH'(mag(b_ext, signed_in));
    assign mp_next   = mp >> STEP;
    assign cnt_next  = cnt + 1'b1;
    assign finish    = (mp_next == '0) || (cnt_next == CW'(ITERS));
    assign ready_out = (state == IDLE);
    assign valid_out = (state == DONE);

    mult_iter_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .acc      (acc),
        .mc       (mc),
        .mp_lo    (mp[STEP-1:0]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            mc    <= '0;
            mp    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            r     <= '0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    mc    <= PW'(a_mag);
                    mp    <= b_mag;
                    neg   <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc   <= '0;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    acc <= acc_next;
                    mc  <= mc << STEP;
                    mp  <= mp_next;
                    cnt <= cnt_next;
                    if (finish) begin
                        r     <= neg ? -acc_next : acc_next;
                        state <= DONE;
                    end
                end
                DONE: if (ready_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplier_iterative_param.sv
// tb_multiplier_iterative_param: checks STEP=1 and STEP=2 instances against an arithmetic model
module tb_multiplier_iterative_param;
    logic        clk = 0, reset = 1, valid_in = 0, ready_in = 0, signed_in = 0;
    logic [31:0] a = 0, b = 0;
    logic        ro1, vo1, ro2, vo2;
    logic [63:0] r1, r2;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    multiplier_iterative_param #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ro1), .a(a), .b(b),
        .signed_in(signed_in), .valid_out(vo1), .ready_in(ready_in), .r(r1)
    );
    multiplier_iterative_param #(.WIDTH(32), .STEP(2)) dut2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ro2), .a(a), .b(b),
        .signed_in(signed_in), .valid_out(vo2), .ready_in(ready_in), .r(r2)
    );

    typedef struct {
        logic [31:0] a, b;
        logic        s;
        logic [63:0] exp_r;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return s ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
    endfunction

    function automatic int ref_lat(input logic [31:0] y, input logic s, input int step);
        logic [31:0] m;
        int nb, k;
        m  = (s && y[31]) ? -y : y;
        nb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) nb = i + 1;
        k = (nb + step - 1) / step;
        return (k < 1) ? 1 : k;
    endfunction

    // Launch one operation on both instances and wait until both present results
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          output int l1, output int l2);
        logic busy_ready_seen;
        busy_ready_seen = 0;
        @(negedge clk);
        a = x; b = y; signed_in = s; valid_in = 1;
        @(negedge clk);
        valid_in = 0;
        l1 = 0; l2 = 0;
        for (int c = 1; c <= 100 && (l1 == 0 || l2 == 0); c++) begin
            if ((l1 == 0 && ro1) || (l2 == 0 && ro2)) busy_ready_seen = 1;
            @(negedge clk);
            if (vo1 && l1 == 0) l1 = c;
            if (vo2 && l2 == 0) l2 = c;
        end
        chk("ready_out_low_while_busy", 64'(busy_ready_seen), 64'd0);
        if (l1 == 0 || l2 == 0) chk("completion_timeout", 64'd1, 64'd0);
    endtask

    task automatic release_result();
        ready_in = 1;
        @(negedge clk);
        ready_in = 0;
    endtask

    task automatic check_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic s,
                            input logic [63:0] exp_r, input int exp_lat1);
        int l1, l2;
        run_op(x, y, s, l1, l2);
        chk({name, "_r_s1"}, r1, exp_r);
        chk({name, "_r_s2"}, r2, exp_r);
        chk({name, "_lat_s1"}, 64'(l1), 64'(exp_lat1));
        chk({name, "_lat_s2"}, 64'(l2), 64'(ref_lat(y, s, 2)));
        release_result();
    endtask

    initial begin
        vec_t vecs[6];
        int   l1, l2;
        logic [31:0] x, y;
        logic s;
        vecs[0] = '{32'd3,        32'd5,        1'b0, 64'h000000000000000F, 3};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 32};
        vecs[2] = '{32'hFFFFFFFD, 32'd7,        1'b1, 64'hFFFFFFFFFFFFFFEB, 3};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 32};
        vecs[4] = '{32'h00001234, 32'd0,        1'b0, 64'h0000000000000000, 1};
        vecs[5] = '{32'd5,        32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFB, 1};

        repeat (2) @(negedge clk);
        chk("reset_ready_out", 64'(ro1), 64'd1);
        chk("reset_valid_out", 64'(vo1), 64'd0);
        chk("reset_r", r1, 64'd0);
        reset = 0;

        for (int i = 0; i < 6; i++) check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                                             vecs[i].exp_r, vecs[i].exp_lat);

        // Backpressure: result held while new operands are offered and ignored
        run_op(32'd9, 32'd11, 1'b0, l1, l2);
        for (int c = 0; c < 5; c++) begin
            a = 32'd77 + c; b = 32'd88; valid_in = c[0];
            @(negedge clk);
            chk("bp_r_stable", r1, 64'd99);
            chk("bp_valid_out", 64'(vo1), 64'd1);
            chk("bp_ready_out", 64'(ro1), 64'd0);
        end
        valid_in = 0;
        release_result();
        chk("bp_idle_ready_out", 64'(ro1), 64'd1);
        chk("bp_idle_valid_out", 64'(vo1), 64'd0);

        // Mid-operation reset discards the in-flight product
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; signed_in = 0; valid_in = 1;
        @(negedge clk);
        valid_in = 0;
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_mid_ready_out", 64'(ro1), 64'd1);
        chk("rst_mid_valid_out", 64'(vo1), 64'd0);
        chk("rst_mid_r", r1, 64'd0);
        chk("rst_mid_r_s2", r2, 64'd0);
        check_op("after_reset", 32'd6, 32'd7, 1'b0, 64'd42, 3);

        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            if (i % 5 == 0) y = -y;
            check_op($sformatf("rand%0d", i), x, y, s, ref_prod(x, y, s), ref_lat(y, s, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
